// File: rtl/reg_mux_n.sv
// reg_mux_n
//   Registered N:1 datapath multiplexer feeding a 2-entry output queue.
//   Each accepted transfer stores {selected word, sel, bad} where bad marks
//   an out-of-range select (its data word is forced to zero). An
//   out-of-range push also sets the sticky err_flag.
//   NUM_IN must not exceed 2**SEL_W.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_data, sel         packed inputs (input k at [k*WIDTH +: WIDTH]), index
//   in_valid, in_ready   producer handshake
//   out_data, out_sel,   head-of-queue word, its select value and
//   out_bad              out-of-range tag (all zero while the queue is empty)
//   out_valid, out_ready consumer handshake
//   err_flag, err_clr    sticky out-of-range flag and its synchronous clear
module reg_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_bad,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_flag,
  input  logic                    err_clr
);

  // Entry 0 is always the head; entry 1 only holds data when count = 2.
  logic [1:0]       count, count_nxt;
  logic [WIDTH-1:0] data0, data1, data0_nxt, data1_nxt;
  logic [SEL_W-1:0] sel0, sel1, sel0_nxt, sel1_nxt;
  logic             bad0, bad1, bad0_nxt, bad1_nxt;
  logic             err_q, err_nxt;

  logic             push, pop;
  logic [WIDTH-1:0] mux_data;
  logic             mux_hit;

  // in_ready comes from registered state only, so there is no path from
  // out_ready back to the producer.
  assign in_ready  = !rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Explicit equality per input instead of a variable part-select, so an
  // out-of-range index can never read beyond the packed vector.
  always_comb begin
    mux_data = '0;
    mux_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_data = in_data[k*WIDTH +: WIDTH];
        mux_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    data0_nxt = data0;
    sel0_nxt  = sel0;
    bad0_nxt  = bad0;
    data1_nxt = data1;
    sel1_nxt  = sel1;
    bad1_nxt  = bad1;
    case ({push, pop})
      2'b10: begin
        count_nxt = count + 2'd1;
        if (count == 2'd0) begin
          data0_nxt = mux_data;
          sel0_nxt  = sel;
          bad0_nxt  = !mux_hit;
        end else begin
          data1_nxt = mux_data;
          sel1_nxt  = sel;
          bad1_nxt  = !mux_hit;
        end
      end
      2'b01: begin
        count_nxt = count - 2'd1;
        data0_nxt = data1;
        sel0_nxt  = sel1;
        bad0_nxt  = bad1;
        data1_nxt = '0;
        sel1_nxt  = '0;
        bad1_nxt  = 1'b0;
      end
      2'b11: begin
        // push needs count < 2 and pop needs count > 0, so count is 1 here:
        // the new word replaces the departing head directly.
        data0_nxt = mux_data;
        sel0_nxt  = sel;
        bad0_nxt  = !mux_hit;
      end
      default: ;
    endcase
  end

  // A bad push in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_nxt = err_q;
    if (err_clr) err_nxt = 1'b0;
    if (push && !mux_hit) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      data0 <= '0;
      sel0  <= '0;
      bad0  <= 1'b0;
      data1 <= '0;
      sel1  <= '0;
      bad1  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count <= count_nxt;
      data0 <= data0_nxt;
      sel0  <= sel0_nxt;
      bad0  <= bad0_nxt;
      data1 <= data1_nxt;
      sel1  <= sel1_nxt;
      bad1  <= bad1_nxt;
      err_q <= err_nxt;
    end
  end

  assign out_data = out_valid ? data0 : '0;
  assign out_sel  = out_valid ? sel0  : '0;
  assign out_bad  = out_valid && bad0;
  assign err_flag = err_q;

endmodule
